// File: rtl/pixel_frame_buffer_pkg.sv
// rtl/pixel_frame_buffer_pkg.sv - canvas constants and FSM encoding shared with the pooling stage
package pixel_frame_buffer_pkg;

    localparam int CANVAS_SIDE    = 112;
    localparam int CANVAS_ADDR_W  = 14;
    localparam int CANVAS_COORD_W = 7;
    localparam int STATE_W        = 2;

    typedef logic [STATE_W-1:0] fb_state_t;

    localparam fb_state_t ST_CLEAR    = 2'd0;
    localparam fb_state_t ST_IDLE     = 2'd1;
    localparam fb_state_t ST_PAINT    = 2'd2;
    localparam fb_state_t ST_DONE_CLR = 2'd3;

    // Brush counters need at least one bit even for a 1x1 brush.
    function automatic int brush_cnt_w(input int brush);
        return (brush > 1) ? $clog2(brush) : 1;
    endfunction

endpackage

// File: rtl/pixel_frame_buffer_if.sv
// rtl/pixel_frame_buffer_if.sv - draw/clear/read bus between the drawing front end and the frame buffer
interface pixel_frame_buffer_if
    import pixel_frame_buffer_pkg::*;
#(
    parameter int COORD_W = CANVAS_COORD_W,
    parameter int ADDR_W  = CANVAS_ADDR_W
);
    logic               draw_valid;
    logic [COORD_W-1:0] draw_x;
    logic [COORD_W-1:0] draw_y;
    logic               draw_ready;
    logic               clear;
    logic               busy;
    logic               clear_done;
    logic [ADDR_W-1:0]  rd_addr;
    logic               rd_data;

    modport master (
        output draw_valid, draw_x, draw_y, clear, rd_addr,
        input  draw_ready, busy, clear_done, rd_data
    );

    modport slave (
        input  draw_valid, draw_x, draw_y, clear, rd_addr,
        output draw_ready, busy, clear_done, rd_data
    );
endinterface

// File: rtl/pixel_frame_buffer_canvas_ram.sv
// rtl/pixel_frame_buffer_canvas_ram.sv - 1-bit canvas RAM, one write port and one registered read port
module canvas_ram #(
    parameter int DEPTH  = 12544,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic              wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic              rdata
);

    logic mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Reads beyond the canvas return 0 rather than aliasing into it.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= 1'b0;
        end else if ({1'b0, raddr} < (ADDR_W + 1)'(DEPTH)) begin
            rdata <= mem[raddr];
        end else begin
            rdata <= 1'b0;
        end
    end

endmodule

// File: rtl/pixel_frame_buffer_counter.sv
// rtl/pixel_frame_buffer_counter.sv - wrap-around counter with enable, synchronous clear and wrap flag
module wrap_counter #(
    parameter int W   = 4,
    parameter int MAX = 15
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap
);

    assign wrap = en && (count == W'(MAX));

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (wrap) begin
            count <= '0;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pixel_frame_buffer.sv
// rtl/pixel_frame_buffer.sv - square 1-bit drawing canvas with auto-clear sweep and clipped square brush
module pixel_frame_buffer
    import pixel_frame_buffer_pkg::*;
#(
    parameter int SIDE    = CANVAS_SIDE,
    parameter int ADDR_W  = $clog2(SIDE * SIDE),
    parameter int COORD_W = $clog2(SIDE),
    parameter int BRUSH   = 2
) (
    input  logic                clk,
    input  logic                reset,
    pixel_frame_buffer_if.slave bus
);

    localparam int DEPTH = SIDE * SIDE;
    localparam int BW    = brush_cnt_w(BRUSH);
    localparam int PW    = COORD_W + 1;

    fb_state_t          state;
    logic [COORD_W-1:0] org_x;
    logic [COORD_W-1:0] org_y;
    logic [ADDR_W-1:0]  clr_addr;
    logic               clr_wrap;
    logic [BW-1:0]      dx;
    logic [BW-1:0]      dy;
    logic               dx_wrap;
    logic               dy_wrap;
    logic [PW-1:0]      px;
    logic [PW-1:0]      py;
    logic               in_canvas;
    logic               accept;
    logic               start_clear;
    logic               we;
    logic               wdata;
    logic [ADDR_W-1:0]  waddr;

    assign start_clear    = (state == ST_IDLE) && bus.clear;
    assign bus.draw_ready = !reset && bus.draw_valid && (state == ST_IDLE) && !bus.clear;
    assign accept         = bus.draw_ready;
    assign bus.busy       = reset || (state != ST_IDLE);
    assign bus.clear_done = !reset && (state == ST_DONE_CLR);

    wrap_counter #(.W(ADDR_W), .MAX(DEPTH - 1)) u_clr_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (start_clear),
        .en    (state == ST_CLEAR),
        .count (clr_addr),
        .wrap  (clr_wrap)
    );

    wrap_counter #(.W(BW), .MAX(BRUSH - 1)) u_dx_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (accept),
        .en    (state == ST_PAINT),
        .count (dx),
        .wrap  (dx_wrap)
    );

    wrap_counter #(.W(BW), .MAX(BRUSH - 1)) u_dy_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (accept),
        .en    ((state == ST_PAINT) && dx_wrap),
        .count (dy),
        .wrap  (dy_wrap)
    );

    // One extra bit so a brush hanging off the right/bottom edge clips instead of wrapping.
    assign px        = PW'(org_x) + PW'(dx);
    assign py        = PW'(org_y) + PW'(dy);
    assign in_canvas = (px < PW'(SIDE)) && (py < PW'(SIDE));

    always_comb begin
        we    = 1'b0;
        wdata = 1'b0;
        waddr = clr_addr;
        if (!reset) begin
            case (state)
                ST_CLEAR: begin
                    we = 1'b1;
                end
                ST_PAINT: begin
                    we    = in_canvas;
                    wdata = 1'b1;
                    waddr = ADDR_W'(py) * ADDR_W'(SIDE) + ADDR_W'(px);
                end
                default: begin
                    we = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_CLEAR;
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (clr_wrap) begin
                        state <= ST_DONE_CLR;
                    end
                end
                ST_DONE_CLR: begin
                    state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (bus.clear) begin
                        state <= ST_CLEAR;
                    end else if (accept) begin
                        state <= ST_PAINT;
                    end
                end
                ST_PAINT: begin
                    if (dx_wrap && dy_wrap) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_CLEAR;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            org_x <= bus.draw_x;
            org_y <= bus.draw_y;
        end
    end

    canvas_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (bus.rd_addr),
        .rdata (bus.rd_data)
    );

endmodule

// File: tb/tb_pixel_frame_buffer.sv
// tb/tb_pixel_frame_buffer.sv - self-checking bench for pixel_frame_buffer against a canvas reference model
module tb_pixel_frame_buffer;
    import pixel_frame_buffer_pkg::*;

    localparam int SIDE  = CANVAS_SIDE;
    localparam int DEPTH = SIDE * SIDE;
    localparam int BRUSH = 2;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    bit   model [DEPTH];

    always #5 clk = ~clk;

    pixel_frame_buffer_if bus ();

    pixel_frame_buffer #(.BRUSH(BRUSH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear;
        for (int i = 0; i < DEPTH; i++) model[i] = 1'b0;
    endtask

    task automatic model_paint(input int x, input int y);
        for (int dy = 0; dy < BRUSH; dy++)
            for (int dx = 0; dx < BRUSH; dx++)
                if (x + dx < SIDE && y + dy < SIDE) model[(y + dy) * SIDE + x + dx] = 1'b1;
    endtask

    task automatic check_read(input string tag, input int addr, input logic exp);
        bus.rd_addr = CANVAS_ADDR_W'(addr);
        tick;
        check($sformatf("%s rd[%0d]", tag, addr), bus.rd_data, exp);
    endtask

    task automatic sweep(input string tag);
        int errs  = 0;
        int first = -1;
        for (int a = 0; a < DEPTH; a++) begin
            bus.rd_addr = CANVAS_ADDR_W'(a);
            tick;
            if (bus.rd_data !== model[a]) begin
                if (errs == 0) first = a;
                errs++;
            end
        end
        check($sformatf("%s bad_addrs first=%0d", tag, first), errs, 0);
    endtask

    // Entered with the DUT at clear address 0; counts busy cycles, clear_done pulses, early acks.
    task automatic run_clear(input string tag);
        int n      = 0;
        int pulses = 0;
        int early  = 0;
        while (bus.busy === 1'b1 && n < 20000) begin
            if (bus.clear_done) pulses++;
            if (bus.draw_ready) early++;
            n++;
            tick;
        end
        check({tag, " busy_cycles"}, n, DEPTH + 1);
        check({tag, " clear_done_pulses"}, pulses, 1);
        check({tag, " draw_ready_while_busy"}, early, 0);
        model_clear();
    endtask

    task automatic paint(input string tag, input int x, input int y);
        int n = 0;
        bus.draw_x     = CANVAS_COORD_W'(x);
        bus.draw_y     = CANVAS_COORD_W'(y);
        bus.draw_valid = 1'b1;
        #1;
        check({tag, " draw_ready"}, bus.draw_ready, 1);
        tick;
        bus.draw_valid = 1'b0;
        while (bus.busy === 1'b1 && n < 100) begin
            n++;
            tick;
        end
        check({tag, " busy_cycles"}, n, BRUSH * BRUSH);
        model_paint(x, y);
    endtask

    initial begin
        int n;
        int x;
        int y;

        reset          = 1'b1;
        bus.clear      = 1'b0;
        bus.draw_valid = 1'b1;
        bus.draw_x     = '0;
        bus.draw_y     = '0;
        bus.rd_addr    = '0;
        repeat (3) tick;
        check("reset busy", bus.busy, 1);
        check("reset draw_ready", bus.draw_ready, 0);
        check("reset clear_done", bus.clear_done, 0);
        check("reset rd_data", bus.rd_data, 0);

        bus.draw_valid = 1'b0;
        reset          = 1'b0;
        #1;
        run_clear("post-reset clear");
        check("idle busy", bus.busy, 0);
        check("idle clear_done", bus.clear_done, 0);

        // First paint at (10,20) doubles as the read-during-write collision test on 2250.
        bus.draw_x     = 7'd10;
        bus.draw_y     = 7'd20;
        bus.draw_valid = 1'b1;
        #1;
        check("p10_20 draw_ready", bus.draw_ready, 1);
        tick;
        bus.draw_valid = 1'b0;
        bus.rd_addr    = 14'd2250;
        tick;
        check("collision old data", bus.rd_data, 0);
        tick;
        check("collision reread", bus.rd_data, 1);
        n = 2;
        while (bus.busy === 1'b1 && n < 100) begin
            n++;
            tick;
        end
        check("p10_20 busy_cycles", n, 4);
        model_paint(10, 20);
        check_read("p10_20", 2250, 1'b1);
        check_read("p10_20", 2251, 1'b1);
        check_read("p10_20", 2362, 1'b1);
        check_read("p10_20", 2363, 1'b1);
        check_read("p10_20", 2249, 1'b0);
        check_read("p10_20", 2252, 1'b0);
        check_read("p10_20", 2361, 1'b0);
        check_read("p10_20", 2364, 1'b0);
        check_read("p10_20", 2138, 1'b0);
        check_read("p10_20", 2475, 1'b0);

        paint("p111_111", 111, 111);
        check_read("p111_111", 12543, 1'b1);
        check_read("p111_111", 0, 1'b0);
        check_read("p111_111", 111, 1'b0);
        paint("p111_50", 111, 50);
        check_read("p111_50", 5711, 1'b1);
        check_read("p111_50", 5823, 1'b1);
        check_read("p111_50", 5712, 1'b0);
        check_read("p111_50", 5824, 1'b0);

        for (int i = 0; i < 24; i++) begin
            x = ($urandom_range(0, 3) == 0) ? SIDE - 1 : $urandom_range(0, SIDE - 1);
            y = ($urandom_range(0, 3) == 0) ? SIDE - 1 : $urandom_range(0, SIDE - 1);
            paint($sformatf("rand%0d", i), x, y);
        end
        sweep("after paints");
        check_read("out of range", 12544, 1'b0);
        check_read("out of range", 16383, 1'b0);

        // clear and draw_valid together: clear wins, draw stays pending until the sweep is done.
        bus.clear      = 1'b1;
        bus.draw_valid = 1'b1;
        bus.draw_x     = 7'd5;
        bus.draw_y     = 7'd5;
        #1;
        check("priority draw_ready", bus.draw_ready, 0);
        tick;
        bus.clear = 1'b0;
        #1;
        check("priority clear entered busy", bus.busy, 1);
        run_clear("priority clear");
        check("post-clear draw_ready", bus.draw_ready, 1);
        tick;
        bus.draw_valid = 1'b0;
        n = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            n++;
            tick;
        end
        check("post-clear paint busy_cycles", n, 4);
        model_paint(5, 5);
        check_read("post-clear", 565, model[565]);
        check_read("post-clear", 678, model[678]);
        check_read("post-clear", 2250, model[2250]);
        check_read("post-clear", 12543, model[12543]);

        bus.draw_x     = 7'd60;
        bus.draw_y     = 7'd70;
        bus.draw_valid = 1'b1;
        #1;
        check("mid-reset paint draw_ready", bus.draw_ready, 1);
        tick;
        tick;
        reset = 1'b1;
        tick;
        #1;
        check("mid-reset busy", bus.busy, 1);
        check("mid-reset draw_ready", bus.draw_ready, 0);
        check("mid-reset rd_data", bus.rd_data, 0);
        tick;
        reset          = 1'b0;
        bus.draw_valid = 1'b0;
        #1;
        run_clear("mid-reset clear");
        sweep("after mid-reset clear");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
